// File: rtl/wb_line_memory_pkg.sv
// Shared types for the Wishbone line-memory responder.
package wb_line_memory_pkg;

  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned LINE_BITS  = 8 * LINE_BYTES;
  localparam int unsigned PADDR_BITS = 12;

  typedef logic [LINE_BITS-1:0]  lc3b_line;
  typedef logic [PADDR_BITS-1:0] lc3b_pmem_addr;
  typedef logic [LINE_BYTES-1:0] lc3b_line_sel;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    REFRESH
  } wbmem_state_t;

endpackage

// File: rtl/wb_line_memory_if.sv
// Memory-side Wishbone bus between the cache master and the line memory.
interface wb_line_memory_if;
  import wb_line_memory_pkg::*;

  lc3b_pmem_addr ADR;
  lc3b_line      DAT_M;
  lc3b_line      DAT_S;
  lc3b_line_sel  SEL;
  logic          CYC;
  logic          STB;
  logic          WE;
  logic          ACK;
  logic          RTY;

  modport master (
    output ADR, DAT_M, SEL, CYC, STB, WE,
    input  DAT_S, ACK, RTY
  );

  modport slave (
    input  ADR, DAT_M, SEL, CYC, STB, WE,
    output DAT_S, ACK, RTY
  );

endinterface

// File: rtl/wb_line_memory_array.sv
// Line storage: 2**IDX_BITS x 128-bit, per-byte write enable, registered read.
module wb_line_array
  import wb_line_memory_pkg::*;
#(
  parameter int unsigned IDX_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] idx,
  input  logic                wr_en,
  input  lc3b_line_sel        wr_sel,
  input  lc3b_line            wr_data,
  input  logic                rd_en,
  output lc3b_line            rd_data
);

  lc3b_line mem [2**IDX_BITS];

  // Byte-masked write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < LINE_BYTES; b++) begin
        if (wr_sel[b]) begin
          mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read register holds its value until the next read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[idx];
    end
  end

endmodule

// File: rtl/wb_line_memory.sv
// Wishbone line-memory responder with fixed latency and periodic refresh windows.
module wb_line_memory
  import wb_line_memory_pkg::*;
#(
  parameter int unsigned IDX_BITS       = 8,
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned REFRESH_PERIOD = 64,
  parameter int unsigned REFRESH_CYCLES = 3
) (
  input logic               clk,
  input logic               rst,
  wb_line_memory_if.slave   wb
);

  localparam int unsigned RC_W  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int unsigned WIN_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [3:0]       LAT_LOAD = 4'(LATENCY - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_PERIOD - 1);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(REFRESH_CYCLES - 1);

  wbmem_state_t        state;
  logic [3:0]          lat_cnt;
  logic [WIN_W-1:0]    win_cnt;
  logic [RC_W-1:0]     ref_cnt;
  logic                refresh_pending;
  logic                refresh_wrap;
  logic                refresh_start;
  logic                request;
  logic                commit;
  logic                ack_q;
  logic [IDX_BITS-1:0] idx_q;
  lc3b_line_sel        sel_q;
  lc3b_line            dat_q;
  logic                we_q;
  lc3b_line            rd_line;

  // Address bits above the index alias onto the same lines.
  logic unused_adr_bits;
  assign unused_adr_bits = ^wb.ADR;

  assign request       = wb.CYC & wb.STB;
  assign refresh_wrap  = (REFRESH_PERIOD != 0) && (ref_cnt == RC_LAST);
  assign refresh_start = (state == IDLE) && refresh_pending;
  assign commit        = (state == WAIT) && wb.CYC && (lat_cnt == 4'd0);

  assign wb.ACK   = ack_q;
  assign wb.RTY   = (state == REFRESH) & request;
  assign wb.DAT_S = rd_line;

  // Free-running refresh timer; a wrap raises a pending refresh, which
  // survives a simultaneous entry into REFRESH so no window is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt         <= '0;
      refresh_pending <= 1'b0;
    end else begin
      if (REFRESH_PERIOD != 0) begin
        ref_cnt <= refresh_wrap ? '0 : ref_cnt + 1'b1;
      end
      if (refresh_wrap) begin
        refresh_pending <= 1'b1;
      end else if (refresh_start) begin
        refresh_pending <= 1'b0;
      end
    end
  end

  // Request sequencing: accept, count down latency, pulse ACK, or sit out a refresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
      win_cnt <= '0;
      ack_q   <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (refresh_pending) begin
            state   <= REFRESH;
            win_cnt <= WIN_LOAD;
          end else if (request) begin
            idx_q   <= wb.ADR[IDX_BITS-1:0];
            sel_q   <= wb.SEL;
            dat_q   <= wb.DAT_M;
            we_q    <= wb.WE;
            lat_cnt <= LAT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (!wb.CYC) begin
            state <= IDLE;
          end else if (lat_cnt == 4'd0) begin
            state <= RESP;
            ack_q <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        REFRESH: begin
          if (win_cnt == '0) begin
            state <= IDLE;
          end else begin
            win_cnt <= win_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  wb_line_array #(
    .IDX_BITS (IDX_BITS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .idx     (idx_q),
    .wr_en   (commit & we_q),
    .wr_sel  (sel_q),
    .wr_data (dat_q),
    .rd_en   (commit & ~we_q),
    .rd_data (rd_line)
  );

endmodule

// File: tb/tb_wb_line_memory.sv
// Randomized bench for wb_line_memory against a transaction-level timing/data model.
module tb_wb_line_memory;

  localparam int unsigned L  = 4;
  localparam int unsigned RP = 16;
  localparam int unsigned RC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_line_memory_if wb();

  wb_line_memory #(
    .IDX_BITS       (8),
    .LATENCY        (L),
    .REFRESH_PERIOD (RP),
    .REFRESH_CYCLES (RC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  // Rising edges since reset release.
  int unsigned n;
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  int checks = 0;
  int errors = 0;

  logic [127:0] mem_m [256];
  logic [127:0] last_rd;
  int unsigned  m_idle_eval;   // first edge at which the memory can take a request
  int unsigned  m_last_entry;  // edge of the most recent refresh entry
  logic [7:0]   pool [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hFF};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Refreshes are owed at every multiple of RP; each one is served at the
  // first idle edge after it, blocks RC cycles, and pushes acceptance out.
  task automatic model_accept(input int unsigned t0, output int unsigned a, output int unsigned exp_rty);
    int unsigned t, w, base, e0;
    t = t0;
    exp_rty = 0;
    forever begin
      base = (m_last_entry > RP) ? m_last_entry : RP;
      w    = ((base + RP - 1) / RP) * RP;
      e0   = (m_idle_eval > w + 1) ? m_idle_eval : w + 1;
      if (e0 <= t) begin
        for (int unsigned c = e0; c < e0 + RC; c++) begin
          if (c + 1 >= t0) exp_rty++;
        end
        m_last_entry = e0;
        m_idle_eval  = e0 + RC + 1;
      end else if (m_idle_eval <= t) begin
        break;
      end else begin
        t = m_idle_eval;
      end
    end
    a = t;
  endtask

  task automatic run_txn(input logic we, input logic [11:0] adr, input logic [15:0] sel,
                         input logic [127:0] dat, input int abort_d, output int unsigned rty_seen);
    int unsigned  t0, a, exp_rty, ack_at, last_n, d;
    logic [127:0] rd_seen;
    logic [7:0]   idx;
    bit           conflict, done, got_ack;
    idx = adr[7:0];
    d   = (abort_d >= 0) ? abort_d : 0;
    @(negedge clk);
    wb.CYC = 1'b1; wb.STB = 1'b1; wb.WE = we; wb.ADR = adr; wb.SEL = sel; wb.DAT_M = dat;
    t0 = n + 1;
    model_accept(t0, a, exp_rty);
    last_n   = (abort_d >= 0) ? a + d + L + 2 : a + L;
    rty_seen = 0; conflict = 0; done = 0; got_ack = 0; ack_at = 0; rd_seen = '0;
    for (int unsigned k = 0; k < 300 && !done; k++) begin
      if (k != 0) @(negedge clk);
      if (abort_d >= 0 && n == a + d) wb.CYC = 1'b0;
      #2;
      if (wb.ACK && wb.RTY) conflict = 1'b1;
      if (wb.RTY) rty_seen++;
      if (wb.ACK && !got_ack) begin
        got_ack = 1'b1;
        ack_at  = n;
        rd_seen = wb.DAT_S;
      end
      if (n >= last_n) done = 1'b1;
    end
    check("txn_bounded", done, 1'b1);
    check("ack_rty_overlap", conflict, 1'b0);
    check("rty_cycles", rty_seen, exp_rty);
    if (abort_d >= 0) begin
      check("abort_no_ack", got_ack, 1'b0);
      wb.CYC = 1'b0; wb.STB = 1'b0;
      m_idle_eval = a + d + 2;
    end else begin
      check("ack_seen", got_ack, 1'b1);
      check("ack_latency", ack_at, a + L);
      if (we) begin
        check("dat_s_hold", rd_seen, last_rd);
        for (int unsigned b = 0; b < 16; b++) begin
          if (sel[b]) mem_m[idx][8*b +: 8] = dat[8*b +: 8];
        end
      end else begin
        check("rd_data", rd_seen, mem_m[idx]);
        last_rd = mem_m[idx];
      end
      @(negedge clk);
      wb.CYC = 1'b0; wb.STB = 1'b0;
      #2;
      check("ack_single", wb.ACK, 1'b0);
      m_idle_eval = a + L + 2;
    end
  endtask

  // Quiet cycles; STB toggles without CYC and must be ignored.
  task automatic idle_gap(input int unsigned cycles);
    bit bad = 1'b0;
    for (int unsigned k = 0; k < cycles; k++) begin
      @(negedge clk);
      wb.CYC = 1'b0;
      wb.STB = 1'($urandom_range(0, 1));
      wb.WE  = 1'($urandom_range(0, 1));
      wb.ADR = 12'($urandom);
      #2;
      if (wb.ACK || wb.RTY) bad = 1'b1;
    end
    wb.STB = 1'b0;
    check("idle_quiet", bad, 1'b0);
  endtask

  task automatic reset_mid_wait();
    int unsigned t0, a, er;
    @(negedge clk);
    wb.CYC = 1'b1; wb.STB = 1'b1; wb.WE = 1'b1; wb.ADR = 12'h012;
    wb.SEL = 16'hFFFF; wb.DAT_M = {4{32'hDEADBEEF}};
    t0 = n + 1;
    model_accept(t0, a, er);
    for (int unsigned k = 0; k < 100 && n < a + 1; k++) @(negedge clk);
    check("rst_reached_wait", n >= a + 1, 1'b1);
    check("rst_pre_dat_s", wb.DAT_S, last_rd);
    #2;
    rst = 1'b1;
    #1;
    check("rst_ack", wb.ACK, 1'b0);
    check("rst_rty", wb.RTY, 1'b0);
    check("rst_dat_s", wb.DAT_S, 128'h0);
    wb.CYC = 1'b0; wb.STB = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    m_idle_eval = 1; m_last_entry = 0; last_rd = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at edge %0d", n);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    wb.CYC = 1'b0; wb.STB = 1'b0; wb.WE = 1'b0;
    wb.ADR = '0; wb.SEL = '0; wb.DAT_M = '0;
    m_idle_eval = 1; m_last_entry = 0; last_rd = '0;

    repeat (3) @(negedge clk);
    #2;
    check("reset_ack", wb.ACK, 1'b0);
    check("reset_rty", wb.RTY, 1'b0);
    check("reset_dat_s", wb.DAT_S, 128'h0);
    rst = 1'b0;

    // Full write then read.
    run_txn(1'b1, 12'h012, 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF, -1, r);
    run_txn(1'b0, 12'h012, 16'h0000, 128'h0, -1, r);
    // Partial write of byte 0.
    run_txn(1'b1, 12'h012, 16'h0001, 128'hAA, -1, r);
    run_txn(1'b0, 12'h012, 16'h0000, 128'h0, -1, r);
    check("partial_line", last_rd, 128'h0123456789ABCDEF0123456789ABCDAA);
    // Alias: upper address bits ignored.
    run_txn(1'b1, 12'h112, 16'hFFFF, rand_line(), -1, r);
    run_txn(1'b0, 12'h012, 16'h0000, 128'h0, -1, r);

    // Request on the cycle right after a refresh-counter wrap.
    idle_gap(20);
    for (int unsigned k = 0; k < 2 * RP && ((n + 1) % RP) != 0; k++) begin
      @(negedge clk);
      wb.STB = 1'b0;
    end
    run_txn(1'b0, 12'h012, 16'h0000, 128'h0, -1, r);
    check("wrap_rty_count", r, RC);

    // Abort a write in its second WAIT cycle, then read the old data.
    idle_gap(2);
    run_txn(1'b1, 12'h012, 16'hFFFF, rand_line(), 1, r);
    idle_gap(2);
    run_txn(1'b0, 12'h012, 16'h0000, 128'h0, -1, r);

    // Reset mid-WAIT discards the uncommitted write.
    idle_gap(2);
    reset_mid_wait();
    run_txn(1'b0, 12'h012, 16'h0000, 128'h0, -1, r);

    // Give every pool line a known value, then randomize.
    foreach (pool[p]) begin
      run_txn(1'b1, {4'($urandom), pool[p]}, 16'hFFFF, rand_line(), -1, r);
      idle_gap(1);
    end
    for (int unsigned i = 0; i < 60; i++) begin
      logic [7:0]  ix;
      logic [11:0] ad;
      int          ab;
      ix = pool[$urandom_range(0, 5)];
      ad = {4'($urandom), ix};
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, L - 1)) : -1;
      if ($urandom_range(0, 1) == 1) run_txn(1'b1, ad, 16'($urandom), rand_line(), ab, r);
      else                           run_txn(1'b0, ad, 16'h0000, 128'h0, ab, r);
      idle_gap($urandom_range(1, 12));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
